wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the register and data-path width.
REQ-002 Parameter ADDR_WIDTH, default 5, SHALL set the register index width (2**ADDR_WIDTH registers).
REQ-003 Parameter CNT_WIDTH, default 16, SHALL set the committed-write counter width.
REQ-004 The block SHALL have a single clock, port clock, and a synchronous active-high reset, port reset: input, 1 bit.
REQ-005 The block SHALL provide ports:
  - readData: input, DATA_WIDTH; memory load data from the MEM/WB register.
  - aluResult: input, DATA_WIDTH; ALU result from the MEM/WB register.
  - muxInst: input, ADDR_WIDTH; destination register index.
  - WB: input, 2 bits; bit1 = RegWrite, bit0 = MemtoReg.
  - readReg1: input, ADDR_WIDTH; ID-stage read index, port 1.
  - readReg2: input, ADDR_WIDTH; ID-stage read index, port 2.
  - readData1: output, DATA_WIDTH; read data, port 1.
  - readData2: output, DATA_WIDTH; read data, port 2.
  - wbData: output, DATA_WIDTH; selected write-back value, used for forwarding.
  - writeCount: output, CNT_WIDTH; count of committed register writes.

Function
REQ-006 wbData SHALL be combinational: readData when WB[0]=1, aluResult when WB[0]=0, regardless of WB[1].
REQ-007 A write SHALL commit at posedge clock when reset=0, WB[1]=1 and muxInst!=0: reg[muxInst] <= wbData.
REQ-008 Writes with muxInst=0 SHALL be discarded; reg[0] SHALL read as 0 at all times.
REQ-009 readDataN SHALL be combinational from readRegN, with zero-cycle latency.
REQ-010 Write-first bypass: when reset=0, WB[1]=1, muxInst!=0 and muxInst==readRegN, readDataN SHALL equal wbData in that same cycle.
REQ-011 Both read ports SHALL bypass independently, including when readReg1==readReg2==muxInst.
REQ-012 readDataN for readRegN=0 SHALL be 0 even when a write to index 0 is presented.
REQ-013 writeCount SHALL increment by 1 on each committed write (REQ-007) only; discarded writes SHALL NOT count.
REQ-014 writeCount SHALL wrap from all-ones to 0 without a flag.
REQ-015 Only one write per cycle is possible; back-to-back writes to the same index SHALL leave the last value.
REQ-016 The block SHALL hold no state other than the registers and writeCount; there SHALL be no stall or handshake, so every qualifying cycle commits.

Reset
REQ-017 At posedge clock with reset=1, all registers SHALL be cleared to 0 and writeCount to 0.
REQ-018 Reset SHALL take priority over a write in the same cycle; that write SHALL be lost and not counted.
REQ-019 While reset=1, readData1 and readData2 SHALL be 0 and bypass SHALL be disabled; wbData SHALL still follow REQ-006.
REQ-020 Asserting reset mid-stream SHALL clear state at the next edge, and the first write after deassertion SHALL count as 1.

Verification
REQ-021 Reset, then read every index on both ports -> all 0; writeCount=0.
REQ-022 Write WB=2'b10, muxInst=5, aluResult=0x12345678; next cycle readReg1=5 -> readData1=0x12345678; writeCount=1.
REQ-023 WB=2'b11, muxInst=9, readData=0xDEADBEEF, readReg1=readReg2=9 in the same cycle -> both outputs 0xDEADBEEF before the edge (bypass); stored after the edge.
REQ-024 WB=2'b10, muxInst=0, aluResult=0xFFFFFFFF -> readData1 (readReg1=0)=0 before and after the edge; writeCount unchanged.
REQ-025 WB=2'b01, muxInst=7, readData=0xAA -> wbData=0xAA, reg[7] unchanged, no count; then reset=1 together with a valid write to reg 3 -> reg 3=0 and writeCount=0.
REQ-026 Preload writeCount to 0xFFFF via 65535 writes, then one more write -> writeCount=0x0000.

Source files
------------

// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - write-back stage / register file bus bundle
//
// Ports (all logic):
//   readData, aluResult  DATA_WIDTH  MEM/WB load data and ALU result
//   muxInst              ADDR_WIDTH  destination register index
//   WB                   2           {RegWrite, MemtoReg}
//   readReg1, readReg2   ADDR_WIDTH  ID-stage read indices
//   readData1, readData2 DATA_WIDTH  read data
//   wbData               DATA_WIDTH  selected write-back value (forwarding)
//   writeCount           CNT_WIDTH   committed-write counter
// master drives the pipeline inputs; slave is the register file.
interface wb_regfile_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0] readData;
    logic [DATA_WIDTH-1:0] aluResult;
    logic [ADDR_WIDTH-1:0] muxInst;
    logic [1:0]            WB;
    logic [ADDR_WIDTH-1:0] readReg1;
    logic [ADDR_WIDTH-1:0] readReg2;
    logic [DATA_WIDTH-1:0] readData1;
    logic [DATA_WIDTH-1:0] readData2;
    logic [DATA_WIDTH-1:0] wbData;
    logic [CNT_WIDTH-1:0]  writeCount;

    modport master (
        output readData, aluResult, muxInst, WB, readReg1, readReg2,
        input  readData1, readData2, wbData, writeCount
    );

    modport slave (
        input  readData, aluResult, muxInst, WB, readReg1, readReg2,
        output readData1, readData2, wbData, writeCount
    );
endinterface

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back stage with write-first register file
//
// Ports:
//   clock  in   single clock
//   reset  in   synchronous, active-high; clears registers and writeCount
//   bus    slave modport of wb_regfile_if (data, indices, WB control,
//          read data, forwarding value and write counter)
module wb_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic           clock,
    input  logic           reset,
    wb_regfile_if.slave    bus
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [CNT_WIDTH-1:0]  write_count_q;
    logic [CNT_WIDTH-1:0]  write_count_d;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  commit;

    // The write-back mux ignores RegWrite and reset so it can always be
    // forwarded; a write commits only outside reset and never to index 0.
    always_comb begin
        wb_data = bus.WB[0] ? bus.readData : bus.aluResult;
        commit  = !reset && bus.WB[1] && (bus.muxInst != '0);
    end

    always_comb begin
        regs_d        = regs_q;
        write_count_d = write_count_q;
        if (commit) begin
            regs_d[bus.muxInst] = wb_data;
            write_count_d       = write_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            write_count_q <= '0;
        end else begin
            regs_q        <= regs_d;
            write_count_q <= write_count_d;
        end
    end

    // Read ports: index 0 and reset force zero; a same-cycle committing
    // write to the read index is forwarded so the reader sees the new value.
    always_comb begin
        bus.readData1 = '0;
        bus.readData2 = '0;
        if (!reset && (bus.readReg1 != '0)) begin
            bus.readData1 = (commit && (bus.muxInst == bus.readReg1))
                          ? wb_data : regs_q[bus.readReg1];
        end
        if (!reset && (bus.readReg2 != '0)) begin
            bus.readData2 = (commit && (bus.muxInst == bus.readReg2))
                          ? wb_data : regs_q[bus.readReg2];
        end
        bus.wbData     = wb_data;
        bus.writeCount = write_count_q;
    end
endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile
module tb_wb_regfile;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] model_regs [32];
    logic [15:0] model_cnt;

    wb_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(16)) bus ();

    wb_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] wb, input logic [4:0] mux,
                         input logic [31:0] rdata, input logic [31:0] alu,
                         input logic [4:0] r1, input logic [4:0] r2);
        rst           = r;
        bus.WB        = wb;
        bus.muxInst   = mux;
        bus.readData  = rdata;
        bus.aluResult = alu;
        bus.readReg1  = r1;
        bus.readReg2  = r2;
    endtask

    function automatic logic [31:0] exp_wb();
        return bus.WB[0] ? bus.readData : bus.aluResult;
    endfunction

    function automatic bit exp_we();
        return !rst && bus.WB[1] && (bus.muxInst != 5'd0);
    endfunction

    // Architectural view of a read: zero during reset or for x0, the value
    // being written this cycle if it targets the index, else stored state.
    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (rst || idx == 5'd0) return 32'h0;
        if (exp_we() && bus.muxInst == idx) return exp_wb();
        return model_regs[idx];
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
            model_cnt = 16'h0;
        end else if (exp_we()) begin
            model_regs[bus.muxInst] = exp_wb();
            model_cnt = model_cnt + 16'd1;
        end
    endtask

    // Check all outputs before the edge, then advance one clock.
    task automatic step(input string tag);
        #1;
        check({tag, "_rd1"}, bus.readData1, exp_read(bus.readReg1));
        check({tag, "_rd2"}, bus.readData2, exp_read(bus.readReg2));
        check({tag, "_wbd"}, bus.wbData, exp_wb());
        check({tag, "_cnt"}, 32'(bus.writeCount), 32'(model_cnt));
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic quiet_cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model_regs[i] = 32'hX;
        model_cnt = 16'hX;

        // Reset with a write presented: outputs zero, wbData still muxes.
        drive(1'b1, 2'b11, 5'd3, 32'hA5A5_0001, 32'h0000_0002, 5'd3, 5'd3);
        quiet_cycle();
        step("rst_hold");
        check("rst_rd1_zero", bus.readData1, 32'h0);

        // All indices read zero after reset.
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 5'(i), 5'(31 - i));
            step("init_read");
        end
        check("init_cnt", 32'(bus.writeCount), 32'h0);

        // ALU write, then read back next cycle.
        drive(1'b0, 2'b10, 5'd5, 32'h0, 32'h1234_5678, 5'd1, 5'd2);
        step("alu_wr");
        drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 5'd5, 5'd0);
        #1;
        check("alu_rd_const", bus.readData1, 32'h1234_5678);
        check("alu_cnt_const", 32'(bus.writeCount), 32'd1);
        step("alu_rd");

        // Dual-port bypass of a load write.
        drive(1'b0, 2'b11, 5'd9, 32'hDEAD_BEEF, 32'h0, 5'd9, 5'd9);
        #1;
        check("byp_rd1_const", bus.readData1, 32'hDEAD_BEEF);
        check("byp_rd2_const", bus.readData2, 32'hDEAD_BEEF);
        step("bypass");
        drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 5'd9, 5'd9);
        step("byp_after");

        // Write to x0 is discarded and not counted.
        drive(1'b0, 2'b10, 5'd0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        step("x0_wr");
        drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 5'd0, 5'd9);
        #1;
        check("x0_rd_const", bus.readData1, 32'h0);
        check("x0_cnt_const", 32'(bus.writeCount), 32'd2);
        step("x0_after");

        // MemtoReg without RegWrite: forwarded value only.
        drive(1'b0, 2'b01, 5'd7, 32'h0000_00AA, 32'h5555_5555, 5'd7, 5'd7);
        #1;
        check("nowr_wbd_const", bus.wbData, 32'h0000_00AA);
        step("nowr");
        drive(1'b0, 2'b10, 5'd3, 32'h0, 32'hCAFE_0003, 5'd3, 5'd7);
        step("pre_rst_wr");

        // Reset beats a simultaneous write.
        drive(1'b1, 2'b10, 5'd3, 32'h0, 32'h1111_2222, 5'd3, 5'd3);
        step("rst_vs_wr");
        drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 5'd3, 5'd7);
        #1;
        check("rst_r3_const", bus.readData1, 32'h0);
        check("rst_cnt_const", 32'(bus.writeCount), 32'h0);
        step("rst_after");

        // Randomized traffic, biased towards index collisions.
        for (int n = 0; n < 300; n++) begin
            logic [4:0] mux;
            mux = 5'($urandom_range(7, 0));
            drive(($urandom_range(39, 0) == 0), 2'($urandom), mux, $urandom, $urandom,
                  ($urandom_range(2, 0) == 0) ? mux : 5'($urandom_range(7, 0)),
                  ($urandom_range(2, 0) == 0) ? mux : 5'($urandom_range(31, 0)));
            step("rand");
        end

        // Fill the counter to all-ones, then wrap it.
        while (model_cnt != 16'hFFFF) begin
            drive(1'b0, 2'b10, 5'($urandom_range(31, 1)), 32'h0, $urandom, 5'd0, 5'd0);
            quiet_cycle();
        end
        drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        #1;
        check("cnt_full_const", 32'(bus.writeCount), 32'h0000_FFFF);
        drive(1'b0, 2'b10, 5'd12, 32'h0, 32'h0BAD_F00D, 5'd12, 5'd0);
        step("wrap_wr");
        drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 5'd12, 5'd0);
        #1;
        check("cnt_wrap_const", 32'(bus.writeCount), 32'h0);
        step("wrap_after");

        // Mid-stream reset; first write afterwards counts as one.
        drive(1'b0, 2'b10, 5'd4, 32'h0, 32'h4444_4444, 5'd4, 5'd12);
        step("mid_wr");
        drive(1'b1, 2'b11, 5'd4, 32'h9999_9999, 32'h0, 5'd4, 5'd12);
        step("mid_rst");
        drive(1'b0, 2'b11, 5'd6, 32'h6666_6666, 32'h0, 5'd4, 5'd6);
        step("mid_first");
        drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 5'd6, 5'd4);
        #1;
        check("mid_cnt_const", 32'(bus.writeCount), 32'd1);
        check("mid_r6_const", bus.readData1, 32'h6666_6666);
        step("mid_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
